// File: rtl/seqr_pkg.sv
// seqr_pkg: shared FSM encodings and RAM address width for ram_wr_seqr.
package seqr_pkg;
  localparam int ADDR_W = 8;
  typedef logic [1:0] state_t;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/wr_addr_ctr.sv
// wr_addr_ctr: 8-bit word counter with synchronous clear, enable and async reset.
module wr_addr_ctr
  import seqr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= q + 1'b1;
endmodule

// File: rtl/ram_wr_seqr.sv
// ram_wr_seqr: loads DEPTH words from a valid/ready source into a RAM write port.
// Optional running checksum of written words under RAM_WR_SEQR_CHECKSUM_EN.
module ram_wr_seqr
  import seqr_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
`ifdef RAM_WR_SEQR_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] chk
`endif
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  state_t state, nxt;
  logic [ADDR_W-1:0] cnt;
  logic xfer, last, go;
  assign din_ready = state == LOAD;
  assign xfer = din_ready && din_valid;
  assign last = xfer && cnt == LAST_ADDR;
  assign go = start && state != LOAD;
  always_comb
    nxt = go ? LOAD : last ? DONE : (state == LOAD || state == DONE) ? state : IDLE;
  wr_addr_ctr u_ctr (
    .clk  (clk),
    .reset(reset),
    .clr  (go),
    .en   (xfer),
    .q    (cnt)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt;
      we    <= xfer;
      busy  <= nxt == LOAD;
      done  <= nxt == DONE;
      if (xfer) begin
        waddr <= cnt;
        wdata <= din;
      end
    end
`ifdef RAM_WR_SEQR_CHECKSUM_EN
  // Sum advances alongside the we pulse it belongs to.
  always_ff @(posedge clk or posedge reset)
    if (reset) chk <= '0;
    else if (go) chk <= '0;
    else if (xfer) chk <= chk + din;
`endif
endmodule

// File: tb/tb_ram_wr_seqr.sv
// tb_ram_wr_seqr: randomized and directed checks of ram_wr_seqr (DEPTH 4 and 256)
// against a transaction-level model of the load sequence.
module tb_ram_wr_seqr;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic start [2], din_valid [2], din_ready [2], we [2], busy [2], done [2];
  logic [7:0] din [2], waddr [2], wdata [2];
  int total = 0, bad = 0;
  int depth [2] = '{4, 256};
  int pulses [2] = '{0, 0};
  logic [7:0] last_addr [2], last_data [2];
  bit m_load [2], m_done [2], m_we [2];
  logic [7:0] m_addr [2], m_data [2], m_chk [2];
  int m_n [2];
`ifdef RAM_WR_SEQR_CHECKSUM_EN
  logic [7:0] chk [2];
`endif

  ram_wr_seqr #(.DEPTH(4), .DATA_W(8)) u_d4 (
    .clk(clk), .reset(reset), .start(start[0]), .din(din[0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .we(we[0]), .waddr(waddr[0]), .wdata(wdata[0]),
    .busy(busy[0]), .done(done[0])
`ifdef RAM_WR_SEQR_CHECKSUM_EN
    , .chk(chk[0])
`endif
  );
  ram_wr_seqr #(.DEPTH(256), .DATA_W(8)) u_d256 (
    .clk(clk), .reset(reset), .start(start[1]), .din(din[1]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .we(we[1]), .waddr(waddr[1]), .wdata(wdata[1]),
    .busy(busy[1]), .done(done[1])
`ifdef RAM_WR_SEQR_CHECKSUM_EN
    , .chk(chk[1])
`endif
  );

  // Model: word n of a load is written to address n mod 256 one cycle after acceptance.
  always @(posedge clk or posedge reset)
    for (int i = 0; i < 2; i++)
      if (reset) begin
        m_load[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_we[i]   <= 1'b0;
        m_addr[i] <= '0;
        m_data[i] <= '0;
        m_chk[i]  <= '0;
        m_n[i]    <= 0;
      end else begin
        m_we[i] <= m_load[i] && din_valid[i];
        if (m_load[i] && din_valid[i]) begin
          m_addr[i] <= 8'(m_n[i]);
          m_data[i] <= din[i];
          m_chk[i]  <= m_chk[i] + din[i];
          m_n[i]    <= m_n[i] + 1;
          if (m_n[i] + 1 == depth[i]) begin
            m_load[i] <= 1'b0;
            m_done[i] <= 1'b1;
          end
        end else if (start[i] && !m_load[i]) begin
          m_load[i] <= 1'b1;
          m_done[i] <= 1'b0;
          m_n[i]    <= 0;
          m_chk[i]  <= '0;
        end
      end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("we%0d", i), 32'(we[i]), 32'(m_we[i]));
      check($sformatf("waddr%0d", i), 32'(waddr[i]), 32'(m_addr[i]));
      check($sformatf("wdata%0d", i), 32'(wdata[i]), 32'(m_data[i]));
      check($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_load[i]));
      check($sformatf("done%0d", i), 32'(done[i]), 32'(m_done[i]));
      check($sformatf("ready%0d", i), 32'(din_ready[i]), 32'(m_load[i]));
`ifdef RAM_WR_SEQR_CHECKSUM_EN
      check($sformatf("chk%0d", i), 32'(chk[i]), 32'(m_chk[i]));
`endif
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    for (int i = 0; i < 2; i++)
      if (we[i]) begin
        pulses[i]++;
        last_addr[i] = waddr[i];
        last_data[i] = wdata[i];
      end
  endtask

  // mode 0: din=A0+n, 1: valid toggling, 2: din=n, 3: checksum table
  task automatic run_load(int i, int mode, int restart_at);
    logic [7:0] tab [4] = '{8'h80, 8'h80, 8'h01, 8'h02};
    pulses[i] = 0;
    start[i] = 1'b1;
    cycle();
    start[i] = 1'b0;
    for (int c = 0; c < 700 && !done[i]; c++) begin
      din_valid[i] = mode == 1 ? c % 2 == 0 : 1'b1;
      din[i] = mode == 3 ? tab[m_n[i] % 4] : mode == 0 ? 8'hA0 + 8'(m_n[i]) : 8'(m_n[i]);
      start[i] = m_n[i] == restart_at;
      cycle();
    end
    din_valid[i] = 1'b0;
    start[i] = 1'b0;
    check("load_done", 32'(done[i]), 1);
    check("load_busy", 32'(busy[i]), 0);
    check("load_pulses", 32'(pulses[i]), 32'(depth[i]));
    check("load_last_addr", 32'(last_addr[i]), 32'(depth[i] - 1));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      din_valid[i] = 1'b0;
      din[i] = '0;
    end
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;
    cycle();
    run_load(0, 0, -1);
    check("d4_last_data", 32'(last_data[0]), 32'h A3);
    run_load(0, 1, -1);
    run_load(0, 0, 2);
    run_load(0, 0, -1);
    run_load(1, 2, -1);
    check("d256_last_data", 32'(last_data[1]), 32'h FF);
`ifdef RAM_WR_SEQR_CHECKSUM_EN
    run_load(0, 3, -1);
    check("chk_at_done", 32'(chk[0]), 32'h03);
`endif
    // Abort after two transfers with an asynchronous reset mid-cycle.
    start[0] = 1'b1;
    cycle();
    start[0] = 1'b0;
    din_valid[0] = 1'b1;
    din[0] = 8'h5A;
    repeat (2) cycle();
    #2 reset = 1'b1;
    #1;
    check("rst_we", 32'(we[0]), 0);
    check("rst_waddr", 32'(waddr[0]), 0);
    check("rst_wdata", 32'(wdata[0]), 0);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    check("rst_ready", 32'(din_ready[0]), 0);
    cycle();
    reset = 1'b0;
    pulses[0] = 0;
    repeat (5) cycle();
    check("rst_no_we", 32'(pulses[0]), 0);
    din_valid[0] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        start[i] = $urandom_range(0, 15) == 0;
        din_valid[i] = $urandom_range(0, 3) != 0;
        din[i] = 8'($urandom);
      end
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_wr_seqr.md
RAM_WR_SEQR -- requirements
Module: ram_wr_seqr

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of words written per load (legal range 1..256).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the width of data words.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port din  input  DATA_W  write data from the source.
REQ-007 SHALL have port din_valid  input  1  source has a valid word on din.
REQ-008 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-009 SHALL have port we  output  1  RAM write enable, one cycle per word.
REQ-010 SHALL have port waddr  output  8  RAM write address.
REQ-011 SHALL have port wdata  output  DATA_W  RAM write data.
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  load complete, held until the next start.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, DONE; all outputs registered except din_ready, which is a decode of state == LOAD.
REQ-015 IDLE: start=1 -> LOAD, word counter cleared to 0; start=0 -> stay.
REQ-016 LOAD: a transfer occurs on a cycle with din_valid=1 and din_ready=1; no transfer occurs otherwise, and counter and outputs hold.
REQ-017 Transfer: next cycle we=1, waddr=counter, wdata=din (latency 1); counter increments by 1, modulo 256.
REQ-018 we SHALL be 0 on every cycle not immediately following a transfer; waddr and wdata hold their last values.
REQ-019 The transfer at counter == DEPTH-1 SHALL move the FSM to DONE; din_ready is 0 from the next cycle on.
REQ-020 DONE: done=1, busy=0; start=1 -> LOAD with counter cleared and done cleared on the next cycle.
REQ-021 busy SHALL be 1 exactly while in LOAD.
REQ-022 start asserted in LOAD SHALL be ignored, with no restart and no counter change.
REQ-023 DEPTH=256: the final write is at waddr=0xFF and the counter wraps to 0x00 with no extra write.
REQ-024 din_valid with the FSM in IDLE or DONE SHALL be ignored (din_ready=0).

Reset
REQ-025 reset=1 SHALL immediately force state=IDLE, counter=0, we=0, waddr=0x00, wdata=0, busy=0, done=0, regardless of clk.
REQ-026 reset asserted mid-LOAD SHALL abort the load, with no further we pulse after reset is released.

Configuration
REQ-027 Macro RAM_WR_SEQR_CHECKSUM_EN defined: SHALL add output chk [DATA_W-1:0], the modulo-2^DATA_W sum of all words written in the current load, updated with each we pulse and cleared on start and reset.
REQ-028 Macro RAM_WR_SEQR_CHECKSUM_EN undefined: no chk port and no checksum logic.

Structure
REQ-029 State encodings (IDLE=2'd0, LOAD=2'd1, DONE=2'd2) and the address width constant (8) SHALL live in the shared package seqr_pkg.
REQ-030 The word counter SHALL be a sub-module wr_addr_ctr (8-bit, synchronous clear, enable, async reset), instantiated once.

Verification
REQ-031 Reset, start, DEPTH=4, din_valid held high with din=0xA0..0xA3 -> we pulses at waddr 0..3 with wdata A0..A3 on consecutive cycles, then done=1 and busy=0.
REQ-032 DEPTH=4, din_valid toggling 1,0,1,0... -> exactly 4 we pulses, with no we on the cycle after a din_valid=0 cycle and addresses contiguous.
REQ-033 DEPTH=256, data = address -> last write at waddr=0xFF with wdata=0xFF, then done=1 and a total of 256 we pulses.
REQ-034 start pulsed at word 2 of 4 -> ignored, and the load completes at waddr 3; start in DONE -> new load from waddr 0.
REQ-035 reset asserted after the second transfer -> all outputs return to 0 asynchronously, no we afterwards, and state is IDLE.
REQ-036 With RAM_WR_SEQR_CHECKSUM_EN, DEPTH=4, data 0x80,0x80,0x01,0x02 -> chk=0x03 at done.
